// File: rtl/qdi_rx_deser.sv
// Clocked receiver for a dual-rail 4-phase QDI channel. It synchronizes each rail,
// deserializes tokens LSB-first into FLIT_W-bit flits and offers them on valid/ready.
module qdi_rx_deser #(
    parameter int unsigned FLIT_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic [1:0]        ch_r,
    output logic              ch_re,
    output logic [FLIT_W-1:0] flit_data,
    output logic              flit_valid,
    input  logic              flit_ready,
    output logic              err
);

    localparam int unsigned CNT_W = $clog2(FLIT_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLIT_W - 1);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_RTZ   = 2'd1,
        S_STALL = 2'd2
    } state_t;

    logic [1:0]             sync_q [SYNC_STAGES];
    logic [1:0]             sync_d [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] sync_vld_q, sync_vld_d;

    state_t                 state_q, state_d;
    logic                   ch_re_q, ch_re_d;
    logic [FLIT_W-2:0]      sh_q, sh_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FLIT_W-1:0]      flit_data_q, flit_data_d;
    logic                   flit_valid_q, flit_valid_d;
    logic                   pend_q, pend_d;
    logic [FLIT_W-1:0]      pend_data_q, pend_data_d;
    logic                   err_q, err_d;

    logic [1:0]             s_c;
    logic                   s_valid_c;
    logic                   s_neutral_c;
    logic                   s_illegal_c;
    logic                   slot_free_c;
    logic [FLIT_W-1:0]      flit_new_c;

    // Rail synchronizer; sync_vld marks stages holding post-reset samples so the
    // zeros left by reset are never mistaken for a neutral from upstream.
    always_comb begin
        sync_d[0] = ch_r;
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
        sync_vld_d = {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
    end

    assign s_c         = sync_q[SYNC_STAGES-1];
    assign s_valid_c   = s_c[1] ^ s_c[0];
    assign s_illegal_c = s_c[1] & s_c[0];
    assign s_neutral_c = (s_c == 2'b00) && (&sync_vld_q);
    assign slot_free_c = !flit_valid_q || flit_ready;
    assign flit_new_c  = {s_c[1], sh_q};

    // Handshake FSM, deserializer and output slot
    always_comb begin
        state_d      = state_q;
        sh_d         = sh_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        pend_data_d  = pend_data_q;
        flit_data_d  = flit_data_q;
        flit_valid_d = flit_valid_q && !flit_ready;
        err_d        = err_q | s_illegal_c;

        case (state_q)
            S_REQ: begin
                if (s_valid_c) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (slot_free_c) begin
                            flit_data_d  = flit_new_c;
                            flit_valid_d = 1'b1;
                        end else begin
                            pend_data_d = flit_new_c;
                            pend_d      = 1'b1;
                        end
                    end else begin
                        for (int i = 0; i < int'(FLIT_W) - 2; i++) begin
                            sh_d[i] = sh_q[i+1];
                        end
                        sh_d[FLIT_W-2] = s_c[1];
                        cnt_d          = cnt_q + CNT_W'(1);
                    end
                    state_d = S_RTZ;
                end
            end
            S_RTZ: begin
                if (s_neutral_c) begin
                    state_d = pend_q ? S_STALL : S_REQ;
                end
            end
            S_STALL: begin
                if (slot_free_c) begin
                    flit_data_d  = pend_data_q;
                    flit_valid_d = 1'b1;
                    pend_d       = 1'b0;
                    state_d      = S_REQ;
                end
            end
            default: state_d = S_RTZ;
        endcase

        ch_re_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= 2'b00;
            end
            sync_vld_q   <= '0;
            state_q      <= S_RTZ;
            ch_re_q      <= 1'b0;
            sh_q         <= '0;
            cnt_q        <= '0;
            flit_data_q  <= '0;
            flit_valid_q <= 1'b0;
            pend_q       <= 1'b0;
            pend_data_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_d[i];
            end
            sync_vld_q   <= sync_vld_d;
            state_q      <= state_d;
            ch_re_q      <= ch_re_d;
            sh_q         <= sh_d;
            cnt_q        <= cnt_d;
            flit_data_q  <= flit_data_d;
            flit_valid_q <= flit_valid_d;
            pend_q       <= pend_d;
            pend_data_q  <= pend_data_d;
            err_q        <= err_d;
        end
    end

    assign ch_re      = ch_re_q;
    assign flit_data  = flit_data_q;
    assign flit_valid = flit_valid_q;
    assign err        = err_q;

endmodule

// File: tb/tb_qdi_rx_deser.sv
// Directed bench for qdi_rx_deser: plays the upstream QDI stage and the consumer,
// checking handshake latency, flit assembly, back-pressure, illegal codes and reset.
module tb_qdi_rx_deser;

    localparam int unsigned FLIT_W      = 8;
    localparam int unsigned SYNC_STAGES = 2;
    // negedges from driving a token (or neutral) until ch_re reacts
    localparam int LAT = SYNC_STAGES + 1;

    logic              clk = 1'b0;
    logic              RESET;
    logic [1:0]        ch_r;
    logic              ch_re;
    logic [FLIT_W-1:0] flit_data;
    logic              flit_valid;
    logic              flit_ready;
    logic              err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    qdi_rx_deser #(
        .FLIT_W     (FLIT_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .RESET     (RESET),
        .ch_r      (ch_r),
        .ch_re     (ch_re),
        .flit_data (flit_data),
        .flit_valid(flit_valid),
        .flit_ready(flit_ready),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_re(input logic v, output int n);
        n = 0;
        while (ch_re !== v && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (ch_re !== v) chk("re_timeout", 32'(ch_re), 32'(v));
    endtask

    // One full 4-phase token; optionally raise flit_ready only for the capture edge.
    task automatic send_bit(input logic b, input logic rdy_at_cap);
        int n;
        wait_re(1'b1, n);
        ch_r = b ? 2'b10 : 2'b01;
        n = 0;
        while (ch_re === 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
            if (rdy_at_cap && n == int'(SYNC_STAGES)) flit_ready = 1'b1;
        end
        if (rdy_at_cap) flit_ready = 1'b0;
        chk("cap_lat", 32'(n), 32'(LAT));
        ch_r = 2'b00;
    endtask

    task automatic send_flit(input logic [7:0] v, input logic rdy_last);
        for (int i = 0; i < 8; i++) begin
            send_bit(v[i], rdy_last && (i == 7));
        end
    endtask

    task automatic pulse_ready();
        flit_ready = 1'b1;
        @(negedge clk);
        flit_ready = 1'b0;
    endtask

    initial begin
        #200000;
        chk("watchdog", 32'(0), 32'(1));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        RESET      = 1'b1;
        ch_r       = 2'b10;
        flit_ready = 1'b0;

        // reset held with a token on the channel
        repeat (2) begin
            @(negedge clk);
            chk("rst_ch_re", 32'(ch_re), 32'(0));
            chk("rst_valid", 32'(flit_valid), 32'(0));
            chk("rst_err", 32'(err), 32'(0));
            chk("rst_data", 32'(flit_data), 32'(0));
        end
        RESET = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("idle_ch_re", 32'(ch_re), 32'(0));
        end
        ch_r = 2'b00;
        wait_re(1'b1, n);
        chk("neutral_lat", 32'(n), 32'(LAT));

        // basic flit 0xA5 (tokens 1,0,1,0,0,1,0,1)
        chk("pre_valid", 32'(flit_valid), 32'(0));
        send_flit(8'hA5, 1'b0);
        chk("basic_valid", 32'(flit_valid), 32'(1));
        chk("basic_data", 32'(flit_data), 32'hA5);
        pulse_ready();
        chk("basic_consumed", 32'(flit_valid), 32'(0));

        // back-pressure: second flit parks in pend, channel stalls
        send_flit(8'hA5, 1'b0);
        send_flit(8'h3C, 1'b0);
        repeat (8) @(negedge clk);
        chk("bp_ch_re", 32'(ch_re), 32'(0));
        chk("bp_data_hold", 32'(flit_data), 32'hA5);
        chk("bp_valid", 32'(flit_valid), 32'(1));
        pulse_ready();
        chk("bp_reload_data", 32'(flit_data), 32'h3C);
        chk("bp_reload_valid", 32'(flit_valid), 32'(1));
        chk("bp_ch_re_back", 32'(ch_re), 32'(1));
        pulse_ready();
        chk("bp_drained", 32'(flit_valid), 32'(0));

        // illegal 11 after 3 bits; flit must hold only the 8 legal bits
        chk("pre_err", 32'(err), 32'(0));
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        wait_re(1'b1, n);
        ch_r = 2'b11;
        repeat (LAT) @(negedge clk);
        chk("ill_err", 32'(err), 32'(1));
        chk("ill_no_capture", 32'(ch_re), 32'(1));
        ch_r = 2'b00;
        repeat (LAT) @(negedge clk);
        chk("ill_ch_re", 32'(ch_re), 32'(1));
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("ill_valid", 32'(flit_valid), 32'(1));
        chk("ill_data", 32'(flit_data), 32'hAB);
        chk("ill_err_sticky", 32'(err), 32'(1));

        // reset mid-flit with a token still driven
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        wait_re(1'b1, n);
        ch_r = 2'b10;
        @(negedge clk);
        RESET = 1'b1;
        @(negedge clk);
        RESET = 1'b0;
        chk("mid_rst_ch_re", 32'(ch_re), 32'(0));
        chk("mid_rst_valid", 32'(flit_valid), 32'(0));
        chk("mid_rst_err", 32'(err), 32'(0));
        repeat (4) begin
            @(negedge clk);
            chk("mid_rst_hold", 32'(ch_re), 32'(0));
        end
        ch_r = 2'b00;
        wait_re(1'b1, n);
        chk("mid_rst_neutral_lat", 32'(n), 32'(LAT));
        send_flit(8'h3C, 1'b0);
        chk("mid_rst_valid2", 32'(flit_valid), 32'(1));
        chk("mid_rst_data", 32'(flit_data), 32'h3C);

        // no-bubble: old flit consumed on the edge that loads the new one
        send_flit(8'h5A, 1'b1);
        chk("nobub_valid", 32'(flit_valid), 32'(1));
        chk("nobub_data", 32'(flit_data), 32'h5A);
        wait_re(1'b1, n);
        chk("nobub_re_lat", 32'(n), 32'(LAT));
        pulse_ready();
        chk("nobub_drained", 32'(flit_valid), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/qdi_rx_deser.md
# qdi_rx_deser

Clocked receiver that sits directly downstream of the PCHB conditional buffer's dual-rail output channel (`ch_r`/`ch_re`). It completes the 4-phase return-to-zero handshake from the clock domain, deserializes one-bit dual-rail tokens LSB-first into `FLIT_W`-bit flits, and presents them on a valid/ready interface to the synchronous router core. It is the async-to-sync boundary of the router datapath.

## Interface
- `FLIT_W`, default 8: bits per flit. Must be ≥ 2.
- `SYNC_STAGES`, default 2: flip-flop synchronizer depth on each rail. Must be ≥ 2.

- `clk`  input  1: receive-domain clock; all state updates on the rising edge.
- `RESET`  input  1: reset, synchronous, active-high.
- `ch_r`  input  2: dual-rail data token. `01` = bit 0, `10` = bit 1, `00` = neutral, `11` = illegal.
- `ch_re`  output  1: enable/acknowledge to the upstream stage. 1 requests data; 0 requests neutral. Registered.
- `flit_data`  output  FLIT_W: assembled flit. Bit 0 is the first token received.
- `flit_valid`  output  1: `flit_data` holds an unconsumed flit.
- `flit_ready`  input  1: consumer accepts the flit when `flit_valid && flit_ready` at a rising edge.
- `err`  output  1: sticky; set when an `11` code is synchronized. Cleared only by `RESET`.

## Operation
- Synchronizer: each rail of `ch_r` passes through `SYNC_STAGES` flops. Decode uses only the synchronized value `s`: valid = exactly one rail high; neutral = `00`.
- Storage: shift register `sh[FLIT_W-2:0]`, bit counter `cnt` (0..FLIT_W-1), output register `flit_data`/`flit_valid`, and a `pend` flag plus a `pend_data` register for one complete flit awaiting the output slot.
- Output slot free this cycle = `!flit_valid || flit_ready`.
- States:
  - `S_REQ` (`ch_re`=1): when `s` is valid, capture bit `s[1]`.
    - If `cnt < FLIT_W-1`: shift the bit in and increment `cnt`.
    - If `cnt == FLIT_W-1`: form the flit `{bit, sh}` and clear `cnt`. If the slot is free, load it into `flit_data` and set `flit_valid`=1. Otherwise store the flit in `pend_data` and set `pend`=1.
    - In all capture cases, go to `S_RTZ`.
  - `S_RTZ` (`ch_re`=0): when `s` is neutral, go to `S_STALL` if `pend`=1, else to `S_REQ`.
  - `S_STALL` (`ch_re`=0): when the slot is free, load `pend_data`, set `flit_valid`=1, clear `pend`, and go to `S_REQ`.
- Back-pressure: the upstream stage is blocked only by `ch_re` staying 0. No token is ever dropped, and at most one flit waits in `pend_data`.
- Illegal `11` on `s`: set `err`=1. No capture, no state change, `cnt` unchanged. Decode resumes on the next legal value.
- `flit_valid` clears on handshake unless a new flit loads in the same cycle. A simultaneous handshake and load keeps `flit_valid`=1 with the new data.
- `flit_data` is stable while `flit_valid && !flit_ready`.

## Timing
- Reset values (registered the cycle `RESET` is sampled high):
  - state `S_RTZ`, `ch_re`=0
  - `flit_valid`=0, `flit_data`=0
  - `cnt`=0, `pend`=0, `err`=0
  - synchronizer flops 0
- After reset, `S_RTZ` waits for a synchronized neutral before raising `ch_re`. This makes reset mid-handshake safe: the upstream stage is never asked for new data while it still drives a token.
- Token-to-capture latency:
  - An edge on `ch_r` settled before clock edge k is decoded at edge k+SYNC_STAGES-1.
  - The bit is captured, and `ch_re` falls, at edge k+SYNC_STAGES.
- Last bit with a free slot: `flit_valid` rises at the same edge as the capture.
- Neutral-to-`ch_re` rise: SYNC_STAGES edges. There is no extra delay.
- Minimum per-bit cycle is 2·SYNC_STAGES clocks, plus upstream delay.
- `ch_re` is driven directly from a flop, so it is glitch-free toward the QDI stage.

## Test plan
1. Reset and idle:
   - Stimulus: hold `RESET`=1 for 2 cycles with `ch_r`=`10`, release, keep `ch_r`=`10` for 5 cycles, then drive `00`.
   - Response: `ch_re`=0, `flit_valid`=0, `err`=0 throughout the hold. `ch_re` rises SYNC_STAGES edges after `00`.
2. Basic flit (FLIT_W=8):
   - Stimulus: drive tokens 1,0,1,0,0,1,0,1 with full 4-phase handshakes. Keep `flit_ready`=0 until the flit appears, then raise it for 1 cycle.
   - Response: `flit_data`=0xA5 and `flit_valid`=1 at the 8th capture edge. `ch_re` toggles once per bit. `flit_valid`=0 after the handshake.
3. Back-pressure:
   - Stimulus: hold `flit_ready`=0 and send flits 0xA5 then 0x3C. Then pulse `flit_ready` for 1 cycle.
   - Response: after the 16th capture and its neutral phase, `ch_re` stays 0. On the pulse, 0xA5 is consumed, 0x3C loads in the same cycle, and `ch_re` returns to 1 on the next edge.
4. Illegal code:
   - Stimulus: after 3 bits, drive `ch_r`=`11`, then `00`, then continue with 5 legal bits.
   - Response: `err`=1 and stays 1. `cnt` is unaffected. The assembled flit contains only the 8 legal bits.
5. Reset mid-flit:
   - Stimulus: after 3 bits, with `ch_r`=`10` held, assert `RESET` for 1 cycle. Then `ch_r`→`00` and send 0x3C.
   - Response: `ch_re`=0 until neutral is synchronized. The old bits are discarded and `flit_data`=0x3C.
6. No-bubble:
   - Stimulus: `flit_valid`=1 and `flit_ready`=1 at the edge that captures the last bit of the next flit.
   - Response: `flit_valid` stays 1 and `flit_data` updates to the new flit in that cycle.
